// File: rtl/perf_pkg.sv
// Shared definitions for the performance monitor: FSM encoding, register
// offsets and CTRL / overflow bit positions.
package perf_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StRun   = 2'd2,
    StDone  = 2'd3
  } perf_state_e;

  localparam logic [7:0] RegCtrl    = 8'h00;
  localparam logic [7:0] RegStatus  = 8'h04;
  localparam logic [7:0] RegStartPc = 8'h08;
  localparam logic [7:0] RegStopPc  = 8'h0C;
  localparam logic [7:0] RegCycle   = 8'h10;
  localparam logic [7:0] RegEvtBase = 8'h20;

  localparam int unsigned CtrlArmBit  = 0;
  localparam int unsigned CtrlClrBit  = 1;
  localparam int unsigned CtrlStopBit = 2;

  localparam int unsigned OvfCycleBit = 8;
  localparam int unsigned OvfW        = 9;

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating up-counter with a sticky overflow flag; clear has priority
// over increment.
module perf_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         ovf
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      if (&cnt) begin
        ovf <= 1'b1;
      end else begin
        cnt <= cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/perf_monitor.sv
// PC-windowed performance monitor: counts cycles and core events between a
// start-PC and stop-PC match, readable through a word-addressed register port.
module perf_monitor
  import perf_pkg::*;
#(
  parameter int unsigned NUM_CNT      = 4,
  parameter int unsigned CNT_W        = 32,
  parameter logic [31:0] START_PC_RST = 32'h4,
  parameter logic [31:0] STOP_PC_RST  = 32'h164,
  parameter bit          AUTO_ARM     = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pc_i,
  input  logic               pc_valid_i,
  input  logic [NUM_CNT-1:0] event_i,
  input  logic               cfg_ce_i,
  input  logic               cfg_we_i,
  input  logic [7:0]         cfg_addr_i,
  input  logic [31:0]        cfg_wdata_i,
  output logic [31:0]        cfg_rdata_o,
  output logic               running_o,
  output logic               done_o
);

  localparam perf_state_e ResetState = perf_state_e'(AUTO_ARM ? StArmed : StIdle);

  // Assert asynchronously, release two clocks after rst rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  perf_state_e       state_q, state_d;
  logic              running_q, done_q;
  logic [31:0]       start_pc_q, stop_pc_q;
  logic [31:0]       rdata_q, rd_val;
  logic [7:0]        addr_w;
  logic              unused_addr;
  logic              wr_en, ctrl_wr, arm_wr, clr_wr, stop_wr, arm_go;
  logic              start_match, stop_match, cnt_en, cnt_clr;
  logic [CNT_W-1:0]  cycle_cnt;
  logic              cycle_ovf;
  logic [CNT_W-1:0]  evt_cnt [NUM_CNT];
  logic [NUM_CNT-1:0] evt_ovf;
  logic [OvfW-1:0]   ovf_vec;

  assign addr_w      = {cfg_addr_i[7:2], 2'b00};
  assign unused_addr = ^cfg_addr_i[1:0];

  assign wr_en   = cfg_ce_i && cfg_we_i;
  assign ctrl_wr = wr_en && (addr_w == RegCtrl);
  assign arm_wr  = ctrl_wr && cfg_wdata_i[CtrlArmBit];
  assign clr_wr  = ctrl_wr && cfg_wdata_i[CtrlClrBit];
  assign stop_wr = ctrl_wr && cfg_wdata_i[CtrlStopBit];
  assign arm_go  = arm_wr && !stop_wr && (state_q == StIdle || state_q == StDone);

  assign start_match = pc_valid_i && (pc_i == start_pc_q);
  assign stop_match  = pc_valid_i && (pc_i == stop_pc_q);

  // The start-match cycle itself belongs to the window.
  assign cnt_en  = (state_q == StRun) || (state_q == StArmed && start_match);
  assign cnt_clr = clr_wr || arm_go;

  always_comb begin
    state_d = state_q;
    if (stop_wr) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  if (arm_wr)      state_d = StArmed;
        StArmed: if (start_match) state_d = StRun;
        StRun:   if (stop_match)  state_d = StDone;
        StDone:  if (arm_wr)      state_d = StArmed;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ResetState;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == StRun);
      done_q    <= (state_d == StDone);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_pc_q <= START_PC_RST;
      stop_pc_q  <= STOP_PC_RST;
    end else begin
      if (wr_en && addr_w == RegStartPc) start_pc_q <= cfg_wdata_i;
      if (wr_en && addr_w == RegStopPc)  stop_pc_q  <= cfg_wdata_i;
    end
  end

  perf_sat_counter #(
    .W(CNT_W)
  ) u_cycle_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (cnt_en),
    .clr  (cnt_clr),
    .cnt  (cycle_cnt),
    .ovf  (cycle_ovf)
  );

  for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_evt
    perf_sat_counter #(
      .W(CNT_W)
    ) u_evt_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .inc  (cnt_en && event_i[gi]),
      .clr  (cnt_clr),
      .cnt  (evt_cnt[gi]),
      .ovf  (evt_ovf[gi])
    );
  end

  always_comb begin
    ovf_vec = '0;
    ovf_vec[OvfCycleBit] = cycle_ovf;
    for (int i = 0; i < NUM_CNT; i++) begin
      ovf_vec[i] = evt_ovf[i];
    end
  end

  always_comb begin
    rd_val = '0;
    case (addr_w)
      RegStatus:  rd_val = {15'd0, ovf_vec, 6'd0, state_q};
      RegStartPc: rd_val = start_pc_q;
      RegStopPc:  rd_val = stop_pc_q;
      RegCycle:   rd_val = 32'(cycle_cnt);
      default: begin
        for (int i = 0; i < NUM_CNT; i++) begin
          if (addr_w == RegEvtBase + 8'(4 * i)) rd_val = 32'(evt_cnt[i]);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (cfg_ce_i && !cfg_we_i) begin
      rdata_q <= rd_val;
    end
  end

  assign cfg_rdata_o = rdata_q;
  assign running_o   = running_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: a 32-bit-counter instance and an 8-bit one
// share all stimulus so saturation can be observed on the narrow copy.
module tb_perf_monitor;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        pc_valid;
  logic [3:0]  event_v;
  logic        cfg_ce, cfg_we;
  logic [7:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] rdata, rdata8;
  logic        running, running8, done, done8;

  int checks   = 0;
  int failures = 0;

  perf_monitor #(
    .NUM_CNT(4), .CNT_W(32), .START_PC_RST(32'h4), .STOP_PC_RST(32'h164), .AUTO_ARM(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .pc_i(pc), .pc_valid_i(pc_valid), .event_i(event_v),
    .cfg_ce_i(cfg_ce), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
    .cfg_rdata_o(rdata), .running_o(running), .done_o(done)
  );

  perf_monitor #(
    .NUM_CNT(4), .CNT_W(8), .START_PC_RST(32'h4), .STOP_PC_RST(32'h164), .AUTO_ARM(1'b1)
  ) dut8 (
    .clk(clk), .rst(rst), .pc_i(pc), .pc_valid_i(pc_valid), .event_i(event_v),
    .cfg_ce_i(cfg_ce), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
    .cfg_rdata_o(rdata8), .running_o(running8), .done_o(done8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
    cfg_ce = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_ce = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic reg_rd(input logic [7:0] a, output logic [31:0] d, output logic [31:0] d8);
    cfg_ce = 1'b1; cfg_we = 1'b0; cfg_addr = a;
    tick();
    cfg_ce = 1'b0;
    d  = rdata;
    d8 = rdata8;
  endtask

  logic [31:0] v, v8;

  initial begin
    rst = 1'b0; pc = '0; pc_valid = 1'b0; event_v = '0;
    cfg_ce = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;

    // Reset state
    #12;
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_running", {31'd0, running}, 32'h0);
    check_eq("rst_done", {31'd0, done}, 32'h0);
    rst = 1'b1;
    repeat (3) tick();
    reg_rd(8'h04, v, v8); check_eq("rst_status_armed", v, 32'h1);
    reg_rd(8'h08, v, v8); check_eq("rst_start_pc", v, 32'h4);
    reg_rd(8'h0C, v, v8); check_eq("rst_stop_pc", v, 32'h164);

    // Full window 0x4..0x164: 7 events inside, 3 outside
    for (int k = 0; k < 90; k++) begin
      pc = 32'(4 * k);
      pc_valid = 1'b1;
      event_v[0] = (k == 0 || k == 1 || k == 10 || k == 20 || k == 30 ||
                    k == 40 || k == 50 || k == 89);
      tick();
      if (k == 0) check_eq("armed_not_running", {31'd0, running}, 32'h0);
      if (k == 1) check_eq("run_after_start", {31'd0, running}, 32'h1);
      if (k == 89) check_eq("done_after_stop", {31'd0, done}, 32'h1);
    end
    for (int k = 0; k < 2; k++) begin
      pc = 32'h168 + 32'(4 * k);
      event_v[0] = 1'b1;
      tick();
    end
    pc_valid = 1'b0; event_v = '0;
    check_eq("running_cleared", {31'd0, running}, 32'h0);
    reg_rd(8'h20, v, v8);
    check_eq("win_evt0", v, 32'd7);
    check_eq("win_evt0_w8", v8, 32'd7);

    // Read latency: value only changes after the read edge
    cfg_ce = 1'b1; cfg_we = 1'b0; cfg_addr = 8'h10;
    check_eq("rd_hold_before_edge", rdata, 32'd7);
    tick();
    cfg_ce = 1'b0;
    check_eq("win_cycle", rdata, 32'd89);
    check_eq("win_cycle_w8", rdata8, 32'd89);
    reg_rd(8'h3C, v, v8); check_eq("unmapped_3c", v, 32'h0);
    reg_rd(8'h00, v, v8); check_eq("ctrl_reads_zero", v, 32'h0);

    // Saturation: rearm, start, event 1 held for 300 window cycles
    reg_wr(8'h00, 32'h1);
    for (int k = 0; k < 300; k++) begin
      pc = 32'h4;
      pc_valid = (k == 0);
      event_v = 4'b0010;
      tick();
    end
    pc_valid = 1'b0; event_v = '0;
    reg_rd(8'h24, v, v8);
    check_eq("sat_evt1_w32", v, 32'd300);
    check_eq("sat_evt1_w8", v8, 32'd255);
    reg_rd(8'h04, v, v8);
    check_eq("sat_status_w32", v, 32'h0000_0002);
    check_eq("sat_status_w8", v8, 32'h0001_0202);
    reg_rd(8'h10, v, v8);
    check_eq("sat_cycle_w32", v, 32'd302);
    check_eq("sat_cycle_w8", v8, 32'd255);

    // Clear in the same cycle as an event: clear wins
    event_v = 4'b0001;
    reg_wr(8'h00, 32'h2);
    event_v = '0;
    reg_rd(8'h20, v, v8); check_eq("clr_wins_evt0", v, 32'd0);
    reg_rd(8'h04, v, v8); check_eq("clr_status_w8", v8, 32'h2);
    event_v = 4'b0001;
    tick();
    event_v = '0;
    reg_rd(8'h20, v, v8); check_eq("evt_after_clr", v, 32'd1);

    // Stop to IDLE, then start == stop PC window
    reg_wr(8'h00, 32'h4);
    reg_rd(8'h04, v, v8); check_eq("stop_to_idle", v, 32'h0);
    reg_wr(8'h08, 32'h40);
    reg_wr(8'h0C, 32'h40);
    reg_wr(8'h00, 32'h1);
    reg_rd(8'h08, v, v8); check_eq("start_pc_wr", v, 32'h40);
    reg_rd(8'h04, v, v8); check_eq("armed_from_idle", v, 32'h1);
    for (int k = 0; k <= 10; k++) begin
      pc = 32'h40;
      pc_valid = (k == 0 || k == 10);
      tick();
      if (k == 0) check_eq("same_pc_run", {31'd0, running}, 32'h1);
      if (k == 5) check_eq("same_pc_still_run", {31'd0, running}, 32'h1);
      if (k == 10) check_eq("same_pc_done", {31'd0, done}, 32'h1);
    end
    pc_valid = 1'b0;
    reg_rd(8'h10, v, v8); check_eq("same_pc_cycle", v, 32'd11);

    // Asynchronous reset mid-window with CYCLE = 20
    reg_wr(8'h00, 32'h1);
    pc = 32'h40; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    reg_rd(8'h08, v, v8);
    repeat (18) tick();
    check_eq("pre_rst_running", {31'd0, running}, 32'h1);
    check_eq("pre_rst_rdata", rdata, 32'h40);
    #2 rst = 1'b0;
    #1;
    check_eq("async_rst_rdata", rdata, 32'h0);
    check_eq("async_rst_running", {31'd0, running}, 32'h0);
    check_eq("async_rst_done", {31'd0, done}, 32'h0);
    #20 rst = 1'b1;
    repeat (3) tick();
    reg_rd(8'h04, v, v8); check_eq("post_rst_armed", v, 32'h1);
    reg_rd(8'h10, v, v8); check_eq("post_rst_cycle", v, 32'h0);
    reg_rd(8'h08, v, v8); check_eq("post_rst_start_pc", v, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/perf_monitor.md
# perf_monitor

Synthesizable performance-monitor unit for the RISC-V pipeline SoC. It counts cycles and up to NUM_CNT core events inside a PC-delimited measurement window, with saturating counters and sticky overflow flags. It sits beside the core and taps the fetch PC and the core's event strobes (branch fetched, branch taken, …). Software or a bench reads results through a small word-addressed register port.

## Interface
- NUM_CNT, 4: number of event counters (1–8)
- CNT_W, 32: width of the cycle counter and each event counter (8–32)
- START_PC_RST, 32'h4: reset value of the start-PC register
- STOP_PC_RST, 32'h164: reset value of the stop-PC register
- AUTO_ARM, 1: 1 means the block leaves reset in ARMED; 0 means it leaves reset in IDLE

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- pc_i  in  32  fetch address of the core (inst_addr)
- pc_valid_i  in  1  pc_i is valid this cycle (inst_ce)
- event_i  in  NUM_CNT  per-cycle event strobes; bit i feeds counter i
- cfg_ce_i  in  1  register access strobe
- cfg_we_i  in  1  1 means write, 0 means read
- cfg_addr_i  in  8  byte address; bits [1:0] are ignored
- cfg_wdata_i  in  32  write data
- cfg_rdata_o  out  32  read data, registered
- running_o  out  1  state == RUN
- done_o  out  1  state == DONE

## Operation
- FSM states are IDLE, ARMED, RUN and DONE.
  - IDLE → ARMED on a CTRL.arm write.
  - ARMED → RUN when pc_valid_i && pc_i == start_pc.
  - RUN → DONE when pc_valid_i && pc_i == stop_pc.
  - DONE → ARMED on a CTRL.arm write.
  - A CTRL.stop write forces IDLE from any state.
- The stop compare is evaluated only in RUN. If start_pc == stop_pc, the start match enters RUN, and the next occurrence of that PC ends the window.
- The window is inclusive of both the start-match cycle and the stop-match cycle.
  - cycle_cnt increments every cycle the FSM is in RUN, plus the start-match cycle.
  - evt_cnt[i] increments in the same cycles whenever event_i[i] = 1.
- Counters saturate at all-ones. An increment attempted at all-ones sets the sticky ovf bit for that counter (bit 8 is the cycle counter, bit i is event counter i) and leaves the value unchanged.
- Register map (word offsets; reads of unmapped addresses return 0; writes to read-only registers are ignored):
  - 0x00 CTRL (write-only, self-clearing): bit0 arm, bit1 clear, bit2 stop.
  - 0x04 STATUS (read-only): [1:0] state (IDLE=0, ARMED=1, RUN=2, DONE=3), [16:8] ovf.
  - 0x08 START_PC (read/write).
  - 0x0C STOP_PC (read/write).
  - 0x10 CYCLE (read-only, zero-extended to 32 bits).
  - 0x20 + 4·i EVT[i] (read-only, zero-extended).
- CTRL.clear zeroes all counters and ovf and does not change the state. When clear is written in the same cycle as an increment, the counter ends at 0 (clear wins).
- CTRL.arm zeroes all counters and ovf as part of arming. Arm is ignored in ARMED and RUN.
- If arm and stop are written in the same cycle, stop wins.
- While in RUN, writes to START_PC and STOP_PC take effect for the next compare.

## Timing
- Reset (rst = 0, asynchronous) sets:
  - state to ARMED if AUTO_ARM, otherwise IDLE
  - all counters and ovf to 0
  - start_pc to START_PC_RST and stop_pc to STOP_PC_RST
  - cfg_rdata_o, running_o and done_o to 0
- Release of rst is synchronised internally by a 2-flop deassertion synchroniser.
- Reset asserted mid-window abandons the measurement. Counters read 0 afterwards.
- Read latency is 1 cycle: with cfg_ce_i = 1 and cfg_we_i = 0 at edge N, cfg_rdata_o is valid after edge N. It holds its value until the next read.
- A write takes effect at the edge where cfg_ce_i = 1.
- A read returns the value as of the start of that cycle, i.e. before any same-cycle increment.
- A start match at edge N gives running_o = 1 and CYCLE = 1 after edge N.
- A stop match at edge M gives done_o = 1 and CYCLE = M − N + 1 after edge M.

## Structure
- Package perf_pkg holds:
  - state encodings
  - register offsets (CTRL, STATUS, START_PC, STOP_PC, CYCLE, EVT_BASE)
  - CTRL bit positions
  - the ovf bit index for the cycle counter (8)
- One sub-module, perf_sat_counter (parameter W; inputs inc, clr; outputs cnt, ovf). It is instantiated NUM_CNT + 1 times.
- The FSM, PC comparators, register decode and read mux live in the top level.

## Test plan
- Default parameters with AUTO_ARM: PC sequence 0x0, 0x4, 0x8, …, 0x164, one PC per cycle → start at 0x4 and stop at 0x164 gives CYCLE = 89 and done_o = 1. EVT[0] equals the number of cycles where event_i[0] = 1 within 0x4..0x164 inclusive; a bench pulsing it 7 times inside the window and 3 times outside reads 7.
- CNT_W = 8, event_i[1] held at 1 for 300 cycles in RUN → EVT[1] = 255 and STATUS[9] = 1. CYCLE is also saturated (255), so STATUS[16] = 1.
- Write START_PC = 0x40 and STOP_PC = 0x40, then CTRL.arm. Two passes through 0x40 spaced 10 cycles apart → RUN after the first pass, DONE after the second, CYCLE = 11.
- Clear written in the same cycle as event_i[0] = 1 in RUN → EVT[0] reads 0. One cycle later an event gives EVT[0] = 1.
- Drive rst low asynchronously mid-window (between clock edges), with CYCLE = 20 → all outputs 0 immediately. After release, STATUS reads ARMED and CYCLE reads 0.
- Read of 0x10 at edge N → cfg_rdata_o updates after edge N only. A read of 0x3C (unmapped, with NUM_CNT = 4) returns 0.
